// File: rtl/shift_result_stage.sv
// Result stage behind the shift ALU: FIFO of {res, op, flags, illegal} plus NZCV, sticky-V and a saturating overflow counter.
// Push-to-out_valid latency is one cycle; in_ready depends only on the registered count, so a full FIFO stalls even if it pops.
module shift_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [31:0]      res_in,
    input  logic             cf_in,
    input  logic             of_in,
    input  logic             zf_in,
    input  logic             nf_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      res_out,
    output logic [3:0]       op_out,
    output logic [3:0]       flags_out,
    output logic             illegal_out,
    output logic [3:0]       psw,
    output logic             sticky_v,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] ovf_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  op;
        logic [3:0]  flags;
        logic        illegal;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic [PW:0]      count_d;
    logic [3:0]       psw_q;
    logic [3:0]       psw_d;
    logic             sticky_q;
    logic             sticky_d;
    logic [CNT_W-1:0] ovf_cnt_q;
    logic [CNT_W-1:0] ovf_cnt_d;
    entry_t           new_entry;
    logic             push;
    logic             pop;
    logic             set_ev;

    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Data inputs are only looked at under push, so idle-cycle garbage never reaches state.
    always_comb begin
        new_entry = '0;
        psw_d     = psw_q;
        sticky_d  = sticky_q;
        ovf_cnt_d = ovf_cnt_q;
        set_ev    = 1'b0;
        count_d   = count_q;
        if (push) begin
            new_entry.res = res_in;
            new_entry.op  = op;
            if (op <= 4'd3) begin
                new_entry.flags = {nf_in, zf_in, cf_in, of_in};
                psw_d           = {nf_in, zf_in, cf_in, of_in};
            end else begin
                new_entry.flags   = psw_q;
                new_entry.illegal = 1'b1;
            end
            set_ev = (op == 4'd3) & of_in;
        end
        if (set_ev) begin
            sticky_d = 1'b1;
            if (ovf_cnt_q != '1) begin
                ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
            end
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            psw_q     <= '0;
            sticky_q  <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= new_entry;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q   <= count_d;
            psw_q     <= psw_d;
            sticky_q  <= sticky_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign res_out     = mem_q[rd_ptr_q].res;
    assign op_out      = mem_q[rd_ptr_q].op;
    assign flags_out   = mem_q[rd_ptr_q].flags;
    assign illegal_out = mem_q[rd_ptr_q].illegal;
    assign psw         = psw_q;
    assign sticky_v    = sticky_q;
    assign ovf_count   = ovf_cnt_q;
endmodule

// File: tb/tb_shift_result_stage.sv
// Bench for shift_result_stage: scoreboard of expected head entries fed by the driver, checked by a negedge monitor.
module tb_shift_result_stage;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, clr_sticky;
    logic [3:0]  op;
    logic [31:0] res_in;
    logic        cf_in, of_in, zf_in, nf_in;

    logic             in_ready, out_valid, illegal_out, sticky_v;
    logic [31:0]      res_out;
    logic [3:0]       op_out, flags_out, psw;
    logic [CNT_W-1:0] ovf_count;

    logic        in_ready2, out_valid2, illegal_out2, sticky_v2;
    logic [31:0] res_out2;
    logic [3:0]  op_out2, flags_out2, psw2;
    logic [1:0]  ovf_count2;

    shift_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .res_in(res_in), .cf_in(cf_in), .of_in(of_in), .zf_in(zf_in), .nf_in(nf_in),
        .out_valid(out_valid), .out_ready(out_ready), .res_out(res_out), .op_out(op_out),
        .flags_out(flags_out), .illegal_out(illegal_out), .psw(psw), .sticky_v(sticky_v),
        .clr_sticky(clr_sticky), .ovf_count(ovf_count)
    );

    // Narrow-counter instance, always drained, so it accepts every in_valid.
    shift_result_stage #(.DEPTH(2), .CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .op(op),
        .res_in(res_in), .cf_in(cf_in), .of_in(of_in), .zf_in(zf_in), .nf_in(nf_in),
        .out_valid(out_valid2), .out_ready(1'b1), .res_out(res_out2), .op_out(op_out2),
        .flags_out(flags_out2), .illegal_out(illegal_out2), .psw(psw2), .sticky_v(sticky_v2),
        .clr_sticky(clr_sticky), .ovf_count(ovf_count2)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  op;
        logic [3:0]  flags;
        logic        ill;
    } exp_t;

    exp_t     exp_q[$];
    logic [3:0] m_psw;
    logic     m_sticky;
    int       m_cnt, m_cnt2;
    int       errors = 0;
    int       checks = 0;
    int       delivered = 0;
    bit       mon_en = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock of stimulus; the reference model advances on the same edge the DUT does.
    task automatic step();
        bit   acc;
        exp_t e;
        @(negedge clk);
        acc = in_valid && in_ready && !rst;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_psw = 4'h0; m_sticky = 1'b0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (acc) begin
                e.res = res_in;
                e.op  = op;
                if (op < 4) begin
                    e.flags = {nf_in, zf_in, cf_in, of_in};
                    e.ill   = 1'b0;
                    m_psw   = e.flags;
                end else begin
                    e.flags = m_psw;
                    e.ill   = 1'b1;
                end
                exp_q.push_back(e);
            end
            if (acc && op == 3 && of_in) begin
                m_sticky = 1'b1;
                m_cnt    = (m_cnt < 255) ? m_cnt + 1 : 255;
            end else if (clr_sticky) begin
                m_sticky = 1'b0;
            end
            if (in_valid && op == 3 && of_in) m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
        #1;
    endtask

    always @(negedge clk) begin
        exp_t h;
        if (mon_en) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("in_ready", in_ready, exp_q.size() < DEPTH);
            chk("psw", psw, m_psw);
            chk("sticky_v", sticky_v, m_sticky);
            chk("ovf_count", ovf_count, m_cnt);
            chk("ovf_count_w2", ovf_count2, m_cnt2);
            if (out_valid && out_ready && !rst && exp_q.size() != 0) begin
                h = exp_q.pop_front();
                chk("res_out", res_out, h.res);
                chk("op_out", op_out, h.op);
                chk("flags_out", flags_out, h.flags);
                chk("illegal_out", illegal_out, h.ill);
                delivered++;
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] o, input logic [31:0] r,
                         input logic n, input logic z, input logic c, input logic ov);
        in_valid = v; op = o; res_in = r;
        nf_in = n; zf_in = z; cf_in = c; of_in = ov;
    endtask

    int snap;

    initial begin
        rst = 1'b1; out_ready = 1'b0; clr_sticky = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) step();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_out", res_out, 0);
        chk("rst_op_out", op_out, 0);
        chk("rst_flags_out", flags_out, 0);
        chk("rst_illegal_out", illegal_out, 0);

        // Single push with Z set
        drive(1, 0, 32'h0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_flags_out", flags_out, 4'b0100);
        chk("t1_psw", psw, 4'b0100);
        out_ready = 1'b1; step();

        // Fill, stall, drain
        out_ready = 1'b0;
        drive(1, 1, 32'h11, 0, 0, 0, 0); step();
        drive(1, 1, 32'h22, 0, 0, 0, 0); step();
        chk("t2_full_in_ready", in_ready, 0);
        drive(1, 1, 32'h33, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0);
        out_ready = 1'b1; step();
        chk("t2_in_ready_after_pop", in_ready, 1);
        chk("t2_second_head", res_out, 32'h22);
        step();

        // Streaming at full rate
        snap = delivered;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, i, 0, (i == 0), 0, 0); step();
        end
        drive(0, 0, 0, 0, 0, 0, 0); step();
        chk("t3_stream_count", delivered - snap, 10);

        // Illegal opcode reuses psw
        out_ready = 1'b0;
        drive(1, 0, 32'hA, 1, 0, 1, 0); step();
        drive(1, 4'b0111, 32'hDEAD_BEEF, 0, 0, 1, 1); step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("t4_psw_kept", psw, 4'b1010);
        out_ready = 1'b1; step(); step();

        // Sticky overflow and counter
        drive(1, 3, 32'h1, 0, 0, 0, 1); step();
        clr_sticky = 1'b1; step();
        chk("t5_set_beats_clr", sticky_v, 1);
        clr_sticky = 1'b0; step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("t5_ovf3", ovf_count, 3);
        clr_sticky = 1'b1; step();
        clr_sticky = 1'b0;
        chk("t5_cleared", sticky_v, 0);
        chk("t5_ovf_kept", ovf_count, 3);
        drive(1, 3, 32'h2, 0, 0, 0, 1); step(); step();
        drive(0, 0, 0, 0, 0, 0, 0); step();
        chk("t5_w2_saturated", ovf_count2, 3);
        chk("t5_ovf5", ovf_count, 5);

        // Reset mid-operation drops the buffered entry
        out_ready = 1'b0;
        drive(1, 0, 32'h55, 1, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 0, 0);
        snap = delivered;
        out_ready = 1'b1; rst = 1'b1; step();
        rst = 1'b0;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_psw", psw, 0);
        chk("t6_ovf", ovf_count, 0);
        step(); step();
        chk("t6_not_delivered", delivered - snap, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 7)), $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            out_ready  = $urandom_range(0, 2) != 0;
            clr_sticky = $urandom_range(0, 7) == 0;
            rst        = $urandom_range(0, 99) == 0;
            step();
        end
        rst = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();
        chk("final_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_result_stage.md
Name: shift_result_stage

Overview:
- Registered stage directly downstream of the combinational shift ALU.
- Captures the ALU result and its flags (carryout, overflow, zero, N) together with the opcode that produced them.
- Buffers the captured entries in a small FIFO behind a valid/ready handshake to the consumer (writeback/register file).
- Maintains the architectural NZCV flag register, a sticky overflow bit and a saturating overflow-event counter.

Parameters:
- DEPTH, 2, number of buffered entries; legal values are 2, 4 and 8.
- CNT_W, 8, width of the overflow-event counter.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream ALU result is valid this cycle.
- in_ready  output  1  stage can accept an entry.
- op  input  4  opcode that produced the result (0 shl, 1 shr, 2 sar, 3 sal).
- res_in  input  32  ALU result.
- cf_in  input  1  ALU carryout.
- of_in  input  1  ALU overflow.
- zf_in  input  1  ALU zero.
- nf_in  input  1  ALU negative.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer takes head entry.
- res_out  output  32  head result.
- op_out  output  4  head opcode.
- flags_out  output  4  head flags as {N,Z,C,V}.
- illegal_out  output  1  head entry came from an opcode above 3.
- psw  output  4  architectural {N,Z,C,V}.
- sticky_v  output  1  sticky overflow flag.
- clr_sticky  input  1  clears sticky_v.
- ovf_count  output  CNT_W  saturating count of accepted sal overflows.

Behaviour:
- Reset (rst=1 at a clock edge): FIFO empties; out_valid=0, res_out=0, op_out=0, flags_out=0, illegal_out=0, psw=0, sticky_v=0, ovf_count=0. in_ready=1 in the cycle after reset.
- Reset mid-operation discards all buffered entries; no partial pop is completed.
- Accept (push) when in_valid & in_ready. Pop when out_valid & out_ready.
- in_ready = (count < DEPTH), derived from registered count only; no combinational path from out_ready. A full FIFO stalls input even if a pop happens that cycle.
- out_valid = (count != 0). Head fields are driven from registered storage.
- Latency: an entry pushed in cycle t is visible with out_valid=1 in cycle t+1.
- Throughput is 1/cycle when count < DEPTH with simultaneous push and pop; count is unchanged in that case.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. The count is log2(DEPTH)+1 bits.
- Storage holds {res, op, flags, illegal} per entry. Head outputs hold their values while out_valid=1 and out_ready=0.
- Legal opcode (op <= 3), on push:
  - Entry flags = {nf_in, zf_in, cf_in, of_in}.
  - psw takes the same value on the accepting edge.
  - illegal bit is stored as 0.
- Illegal opcode (op >= 4), on push:
  - Entry flags = current psw (the value before this edge).
  - psw is unchanged.
  - illegal bit is stored as 1.
  - res_in is stored unmodified.
- Sticky overflow:
  - Set event: a push with op==3 and of_in==1.
  - Set and clr_sticky in the same cycle: set wins, so sticky_v=1.
  - Otherwise clr_sticky=1 forces sticky_v=0.
- ovf_count increments on every set event and saturates at 2^CNT_W-1; it is cleared only by rst.
- Inputs are ignored when in_valid=0. X on data inputs with in_valid=0 must not propagate to state.
- Pop on an empty FIFO is impossible because out_valid=0. Push on a full FIFO is impossible because in_ready=0.

Test Plan:
- Reset, then a single push of op=0, res_in=0x0000_0000, zf_in=1, other flags 0 -> next cycle out_valid=1, res_out=0, flags_out=4'b0100, psw=4'b0100, illegal_out=0.
- Hold out_ready=0 and push DEPTH=2 entries (res 0x11, then 0x22) -> in_ready=0 after the second push; a third in_valid is not accepted. Release out_ready -> 0x11 then 0x22 popped on consecutive cycles; in_ready returns to 1 after the first pop.
- Continuous in_valid/out_ready=1 for 10 pushes with res_in=i -> res_out sequence 0..9, one per cycle, with 1-cycle latency and no bubbles; count never exceeds 1.
- Set psw=4'b1010 via a legal push, then push op=4'b0111 with cf_in=1 and of_in=1 -> flags_out=4'b1010, illegal_out=1, psw stays 4'b1010.
- Push op=3 with of_in=1 three times, asserting clr_sticky on the same cycle as the second push -> sticky_v=1 throughout, ovf_count=3. Then clr_sticky alone -> sticky_v=0 and ovf_count stays 3. With CNT_W=2, five events -> ovf_count saturates at 3.
- Fill 1 entry, then assert rst for one cycle while out_ready=1 -> out_valid=0, psw=0, ovf_count=0 on the next cycle; the entry is never delivered.
